// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: maps the raster position onto a sprite ROM address, registers the texel,
// drops transparent texels, latches position/mirror per frame and blinks the sprite after a hit.
module player_sprite_renderer #(
  parameter int unsigned              ADDRESS      = 10,
  parameter int unsigned              COLOR_BITS   = 24,
  parameter int unsigned              H_ACTIVE     = 640,
  parameter int unsigned              V_ACTIVE     = 480,
  parameter logic [COLOR_BITS-1:0]    TRANSPARENT  = '0,
  parameter int unsigned              BLINK_FRAMES = 48
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [10:0]           i_hcount,
  input  logic [10:0]           i_vcount,
  input  logic                  i_video_on,
  input  logic [10:0]           i_pos_x,
  input  logic [10:0]           i_pos_y,
  input  logic                  i_mirror,
  input  logic                  i_hit,
  output logic [ADDRESS-1:0]    o_rom_addr,
  input  logic [COLOR_BITS-1:0] i_rom_data,
  output logic                  o_sprite_on,
  output logic [COLOR_BITS-1:0] o_sprite_rgb,
  output logic                  o_blinking
);

  localparam int unsigned HALF = ADDRESS / 2;
  localparam int unsigned SIDE = 1 << HALF;
  localparam int unsigned CW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] BLINK_LOAD = CW'(BLINK_FRAMES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BLINK = 1'b1;

  // Frame-synchronous state
  logic [10:0]           r_lx;
  logic [10:0]           r_ly;
  logic                  r_mirror;
  logic [0:0]            r_state;
  logic [CW-1:0]         r_cnt;

  // Pipeline state
  logic [ADDRESS-1:0]    r_rom_addr;
  logic                  r_in_box;
  logic                  r_visible;
  logic                  r_sprite_on;
  logic [COLOR_BITS-1:0] r_sprite_rgb;

  logic                  w_frame_tick;
  logic [0:0]            w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_visible;
  logic                  w_on_screen;
  logic                  w_in_x;
  logic                  w_in_y;
  logic                  w_in_box;
  logic [HALF-1:0]       w_lcol;
  logic [HALF-1:0]       w_lrow;
  logic [HALF-1:0]       w_col;
  logic                  w_opaque;

  assign w_frame_tick = (i_hcount == 11'd0) && (i_vcount == 11'(V_ACTIVE));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lx     <= '0;
      r_ly     <= '0;
      r_mirror <= 1'b0;
    end else if (w_frame_tick) begin
      r_lx     <= i_pos_x;
      r_ly     <= i_pos_y;
      r_mirror <= i_mirror;
    end
  end

  // A hit reloads the counter even on a frame tick, so the reload is never decremented away.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_hit) begin
      w_state_nxt = ST_BLINK;
      w_cnt_nxt   = BLINK_LOAD;
    end else if (w_frame_tick && (r_state == ST_BLINK)) begin
      if (r_cnt == CW'(1)) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter is zero in idle, so this also yields an always-visible idle sprite.
  assign w_visible = ~r_cnt[2];

  // Box compares are done one bit wider so a box near the 11-bit limit never wraps.
  assign w_on_screen = i_video_on && (i_hcount < 11'(H_ACTIVE)) && (i_vcount < 11'(V_ACTIVE));
  assign w_in_x      = ({1'b0, i_hcount} >= {1'b0, r_lx}) &&
                       ({1'b0, i_hcount} <  ({1'b0, r_lx} + 12'(SIDE)));
  assign w_in_y      = ({1'b0, i_vcount} >= {1'b0, r_ly}) &&
                       ({1'b0, i_vcount} <  ({1'b0, r_ly} + 12'(SIDE)));
  assign w_in_box    = w_on_screen && w_in_x && w_in_y;

  assign w_lcol = HALF'(i_hcount - r_lx);
  assign w_lrow = HALF'(i_vcount - r_ly);
  assign w_col  = r_mirror ? ~w_lcol : w_lcol;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rom_addr <= '0;
      r_in_box   <= 1'b0;
      r_visible  <= 1'b0;
    end else begin
      if (w_in_box) begin
        r_rom_addr <= {w_lrow, w_col};
      end
      r_in_box  <= w_in_box;
      r_visible <= w_visible;
    end
  end

  assign w_opaque = r_in_box && r_visible && (i_rom_data != TRANSPARENT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sprite_on  <= 1'b0;
      r_sprite_rgb <= '0;
    end else begin
      r_sprite_on  <= w_opaque;
      r_sprite_rgb <= w_opaque ? i_rom_data : '0;
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_sprite_on  = r_sprite_on;
  assign o_sprite_rgb = r_sprite_rgb;
  assign o_blinking   = (r_state == ST_BLINK);

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Bench for player_sprite_renderer: directed raster vectors, a per-pixel reference model with a
// two-cycle delay, and literal spot checks on addresses, colours and blink timing.
module tb_player_sprite_renderer;

  localparam int SIDE = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount, vcount, pos_x, pos_y;
  logic        video_on, mirror, hit;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data;
  logic        sprite_on;
  logic [23:0] sprite_rgb;
  logic        blinking;

  logic [23:0] rom [1024];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  player_sprite_renderer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hcount     (hcount),
    .i_vcount     (vcount),
    .i_video_on   (video_on),
    .i_pos_x      (pos_x),
    .i_pos_y      (pos_y),
    .i_mirror     (mirror),
    .i_hit        (hit),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_sprite_on  (sprite_on),
    .o_sprite_rgb (sprite_rgb),
    .o_blinking   (blinking)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: state of the frame (latched box, blink frames remaining) and the pixel
  // each raster input must produce two clocks later.
  int          m_lx, m_ly, m_cnt, m_addr;
  bit          m_mir, m_live = 1'b0;
  bit          p_on, e_on;
  logic [23:0] p_rgb, e_rgb;

  always @(posedge clk) begin
    int  h, v, col, row, idx;
    bit  inbox, vis, pon, tk;
    logic [23:0] prgb;
    if (!rst_n) begin
      m_lx = 0; m_ly = 0; m_mir = 0; m_cnt = 0; m_addr = 0;
      p_on = 0; p_rgb = 0; e_on = 0; e_rgb = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      h = int'(hcount);
      v = int'(vcount);
      inbox = video_on && h >= m_lx && h < m_lx + SIDE && v >= m_ly && v < m_ly + SIDE;
      vis = ((m_cnt / 4) % 2) == 0;
      idx = 0;
      if (inbox) begin
        col = h - m_lx;
        if (m_mir) col = SIDE - 1 - col;
        row = v - m_ly;
        idx = row * SIDE + col;
      end
      pon  = inbox && vis && (rom[idx] != 24'h0);
      prgb = pon ? rom[idx] : 24'h0;
      e_on = p_on; e_rgb = p_rgb;
      p_on = pon;  p_rgb = prgb;
      if (inbox) m_addr = idx;
      tk = (h == 0) && (v == 480);
      if (tk) begin
        m_lx = int'(pos_x); m_ly = int'(pos_y); m_mir = mirror;
      end
      if (hit) m_cnt = 48;
      else if (tk && m_cnt > 0) m_cnt = m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("model sprite_on", 32'(sprite_on), 32'(e_on));
      chk("model sprite_rgb", 32'(sprite_rgb), 32'(e_rgb));
      chk("model blinking", 32'(blinking), 32'(m_cnt != 0));
    end
  end

  task automatic cyc(input int h, input int v, input bit von, input bit ht = 1'b0,
                     input bit rs = 1'b1);
    @(negedge clk);
    hcount = 11'(h); vcount = 11'(v); video_on = von; hit = ht; rst_n = rs;
  endtask

  task automatic idle();
    cyc(700, 600, 1'b0);
  endtask

  task automatic tick();
    cyc(0, 480, 1'b0);
  endtask

  // Drive one raster pixel and wait until its sprite output is on the pins.
  task automatic pix(input int h, input int v);
    cyc(h, v, 1'b1);
    idle();
    idle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 24'h100000 | 24'(i);
    rom[5] = 24'h0;
    rst_n = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
    pos_x = 11'd100; pos_y = 11'd50; mirror = 1'b0; hit = 1'b0;

    cyc(700, 600, 1'b0, 1'b0, 1'b0);
    cyc(700, 600, 1'b0, 1'b0, 1'b0);
    idle();
    chk("reset rom_addr", 32'(rom_addr), 32'd0);
    chk("reset sprite_on", 32'(sprite_on), 32'd0);
    chk("reset blinking", 32'(blinking), 32'd0);

    // Basic draw at (100,50)
    tick();
    cyc(100, 50, 1'b1);
    idle();
    chk("basic addr(100,50)", 32'(rom_addr), 32'd0);
    idle();
    chk("basic on(100,50)", 32'(sprite_on), 32'd1);
    chk("basic rgb(100,50)", 32'(sprite_rgb), 32'h100000);
    cyc(131, 81, 1'b1);
    idle();
    chk("basic addr(131,81)", 32'(rom_addr), 32'd1023);
    idle();
    chk("basic rgb(131,81)", 32'(sprite_rgb), 32'h1003FF);
    pix(132, 50);
    chk("basic off(132,50)", 32'(sprite_on), 32'd0);
    pix(105, 50);
    chk("transparent on", 32'(sprite_on), 32'd0);
    chk("transparent rgb", 32'(sprite_rgb), 32'd0);
    for (int h = 95; h < 136; h++) cyc(h, 51, 1'b1);
    idle(); idle();

    // Mirror
    mirror = 1'b1;
    tick();
    cyc(100, 50, 1'b1);
    idle();
    chk("mirror addr(100,50)", 32'(rom_addr), 32'd31);
    cyc(131, 51, 1'b1);
    idle();
    chk("mirror addr(131,51)", 32'(rom_addr), 32'd32);
    for (int h = 98; h < 134; h++) cyc(h, 52, 1'b1);
    idle(); idle();

    // Clipping at the right edge
    mirror = 1'b0; pos_x = 11'd620;
    tick();
    pix(639, 60);
    chk("clip on(639,60)", 32'(sprite_on), 32'd1);
    chk("clip rgb(639,60)", 32'(sprite_rgb), 32'h100153);
    cyc(645, 60, 1'b0);
    idle(); idle();
    chk("clip off(645,60)", 32'(sprite_on), 32'd0);
    for (int h = 615; h < 661; h++) cyc(h, 61, h < 640);
    idle(); idle();

    // Tear-free position latch
    pos_x = 11'd100;
    tick();
    pix(100, 52);
    chk("tear on before move", 32'(sprite_rgb), 32'h100040);
    pos_x = 11'd200;
    pix(100, 53);
    chk("tear old x mid-frame", 32'(sprite_rgb), 32'h100060);
    pix(200, 53);
    chk("tear new x mid-frame", 32'(sprite_on), 32'd0);
    tick();
    pix(200, 53);
    chk("tear new x next frame", 32'(sprite_rgb), 32'h100060);
    pix(100, 53);
    chk("tear old x next frame", 32'(sprite_on), 32'd0);

    // Blink after a hit
    pos_x = 11'd100;
    tick();
    cyc(700, 600, 1'b0, 1'b1);
    pix(110, 55);
    chk("blink start blinking", 32'(blinking), 32'd1);
    chk("blink start visible", 32'(sprite_on), 32'd1);
    for (int f = 1; f <= 50; f++) begin
      tick();
      pix(110, 55);
      if (f == 1) chk("blink f1 hidden", 32'(sprite_on), 32'd0);
      if (f == 5) chk("blink f5 visible", 32'(sprite_on), 32'd1);
      if (f == 47) chk("blink f47 blinking", 32'(blinking), 32'd1);
      if (f == 48) chk("blink f48 done", 32'(blinking), 32'd0);
    end

    // Second hit at frame 20 restarts the blink
    cyc(700, 600, 1'b0, 1'b1);
    for (int f = 1; f <= 70; f++) begin
      tick();
      if (f == 20) begin
        pix(110, 55);
        chk("rehit f20 hidden", 32'(sprite_on), 32'd0);
        cyc(700, 600, 1'b0, 1'b1);
      end
      pix(110, 55);
      if (f == 20) chk("rehit f20 reload visible", 32'(sprite_on), 32'd1);
      if (f == 67) chk("rehit f67 blinking", 32'(blinking), 32'd1);
      if (f == 68) chk("rehit f68 done", 32'(blinking), 32'd0);
    end

    // Hit coincident with the frame tick
    cyc(0, 480, 1'b0, 1'b1);
    pix(110, 55);
    chk("coincident visible", 32'(sprite_on), 32'd1);
    for (int f = 1; f <= 49; f++) begin
      tick();
      pix(110, 55);
      if (f == 1) chk("coincident f1 hidden", 32'(sprite_on), 32'd0);
      if (f == 47) chk("coincident f47 blinking", 32'(blinking), 32'd1);
      if (f == 48) chk("coincident f48 done", 32'(blinking), 32'd0);
    end

    // Reset while drawing and blinking
    cyc(700, 600, 1'b0, 1'b1);
    cyc(110, 55, 1'b1);
    cyc(111, 55, 1'b1);
    cyc(112, 55, 1'b1);
    chk("prereset sprite_on", 32'(sprite_on), 32'd1);
    chk("prereset blinking", 32'(blinking), 32'd1);
    cyc(113, 55, 1'b1, 1'b0, 1'b0);
    idle();
    chk("reset mid sprite_on", 32'(sprite_on), 32'd0);
    chk("reset mid rom_addr", 32'(rom_addr), 32'd0);
    chk("reset mid blinking", 32'(blinking), 32'd0);
    pix(0, 0);
    chk("reset pos origin on", 32'(sprite_on), 32'd1);
    chk("reset pos origin rgb", 32'(sprite_rgb), 32'h100000);
    pix(100, 50);
    chk("reset pos old box off", 32'(sprite_on), 32'd0);

    idle(); idle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
